mnist_result_streamer: RTL and testbench

Output-side reader for the MNIST classifier's final layer. On a `done_in` pulse it snapshots the packed class scores (`result_vector`) and `predicted_class`. It then serialises them as a framed byte stream on a valid/ready master port toward the host link (UART/FIFO bridge). This frees the layer to start the next inference while the previous result drains.

---
 rtl/mnist_result_streamer.sv | 156 +++++++++++++++
 tb/tb_mnist_result_streamer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_result_streamer.sv
// Snapshots final-layer scores on done_in and streams an A5-framed byte frame; first byte valid one cycle after capture.
// m_valid/m_data registered and held under backpressure; trailing XOR checksum byte only when MNIST_STREAM_CKSUM_EN is defined.
module mnist_result_streamer #(
  parameter int         ACC_WIDTH = 32,
  parameter int         NUM_PES   = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         done_in,
  input  logic [ACC_WIDTH*NUM_PES-1:0] result_vector,
  input  logic [3:0]                   predicted_class,
  output logic [7:0]                   m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         dropped
);
  localparam int BPW = ACC_WIDTH / 8;
  localparam int WW  = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(NUM_PES - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);

`ifdef MNIST_STREAM_CKSUM_EN
  typedef enum logic [2:0] {IDLE, SYNC, CLASS, PAYLOAD, CKSUM} state_t;
  logic [7:0] cksum, cksum_nxt;
`else
  typedef enum logic [1:0] {IDLE, SYNC, CLASS, PAYLOAD} state_t;
`endif

  state_t                       state, state_nxt;
  logic [WW-1:0]                word_cnt, word_nxt;
  logic [BW-1:0]                byte_cnt, byte_nxt;
  logic [ACC_WIDTH*NUM_PES-1:0] shadow_vec;
  logic [3:0]                   shadow_class;
  logic [7:0]                   data_nxt;
  logic                         valid_nxt, done_nxt, drop_nxt, hs;

  assign hs   = m_valid && m_ready;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    word_nxt  = word_cnt;
    byte_nxt  = byte_cnt;
    data_nxt  = m_data;
    valid_nxt = m_valid;
    done_nxt  = 1'b0;
    drop_nxt  = done_in && (state != IDLE);
`ifdef MNIST_STREAM_CKSUM_EN
    cksum_nxt = cksum;
`endif
    unique case (state)
      IDLE: begin
        if (done_in) begin
          state_nxt = SYNC;
          valid_nxt = 1'b1;
          data_nxt  = SYNC_BYTE;
          word_nxt  = '0;
          byte_nxt  = '0;
`ifdef MNIST_STREAM_CKSUM_EN
          cksum_nxt = 8'h00;
`endif
        end
      end
      SYNC: begin
        if (hs) begin
          state_nxt = CLASS;
          data_nxt  = {4'h0, shadow_class};
        end
      end
      CLASS: begin
        if (hs) begin
          state_nxt = PAYLOAD;
          data_nxt  = shadow_vec[7:0];
`ifdef MNIST_STREAM_CKSUM_EN
          cksum_nxt = cksum ^ m_data;
`endif
        end
      end
      PAYLOAD: begin
        if (hs) begin
`ifdef MNIST_STREAM_CKSUM_EN
          cksum_nxt = cksum ^ m_data;
`endif
          if (byte_cnt == LAST_BYTE) begin
            byte_nxt = '0;
            if (word_cnt == LAST_WORD) begin
`ifdef MNIST_STREAM_CKSUM_EN
              state_nxt = CKSUM;
              data_nxt  = cksum ^ m_data;
`else
              state_nxt = IDLE;
              valid_nxt = 1'b0;
              data_nxt  = 8'h00;
              done_nxt  = 1'b1;
`endif
            end else begin
              word_nxt = word_cnt + 1'b1;
            end
          end else begin
            byte_nxt = byte_cnt + 1'b1;
          end
          // Next byte is preloaded so m_data stays a pure register output.
          if (state_nxt == PAYLOAD)
            data_nxt = shadow_vec[(int'(word_nxt) * BPW + int'(byte_nxt)) * 8 +: 8];
        end
      end
`ifdef MNIST_STREAM_CKSUM_EN
      CKSUM: begin
        if (hs) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          data_nxt  = 8'h00;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      shadow_vec   <= '0;
      shadow_class <= '0;
      m_data       <= 8'h00;
      m_valid      <= 1'b0;
      frame_done   <= 1'b0;
      dropped      <= 1'b0;
`ifdef MNIST_STREAM_CKSUM_EN
      cksum        <= 8'h00;
`endif
    end else begin
      state      <= state_nxt;
      word_cnt   <= word_nxt;
      byte_cnt   <= byte_nxt;
      m_data     <= data_nxt;
      m_valid    <= valid_nxt;
      frame_done <= done_nxt;
      dropped    <= drop_nxt;
`ifdef MNIST_STREAM_CKSUM_EN
      cksum      <= cksum_nxt;
`endif
      if (state == IDLE && done_in) begin
        shadow_vec   <= result_vector;
        shadow_class <= predicted_class;
      end
    end
  end
endmodule

// File: tb/tb_mnist_result_streamer.sv
// Bench for mnist_result_streamer: fixed frame table, hand-written corner sequences, then random frames with stalls and spurious done_in.
// Outputs are observed 1 time unit after each rising edge, inputs driven at the same point.
module tb_mnist_result_streamer;
  localparam int AW = 32;
  localparam int NP = 10;
  localparam int VW = AW * NP;
`ifdef MNIST_STREAM_CKSUM_EN
  localparam int FRAME_LEN = 2 + NP * AW / 8 + 1;
`else
  localparam int FRAME_LEN = 2 + NP * AW / 8;
`endif

  logic          clk;
  logic          reset;
  logic          done_in;
  logic [VW-1:0] result_vector;
  logic [3:0]    predicted_class;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          frame_done;
  logic          dropped;

  mnist_result_streamer #(.ACC_WIDTH(AW), .NUM_PES(NP), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .result_vector(result_vector),
    .predicted_class(predicted_class), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .frame_done(frame_done), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int drop_cnt = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [VW-1:0] vec;
    logic [3:0]    cls;
    logic [7:0]    last_ck;
    logic [7:0]    last_pl;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock: record an accepted byte, advance, then observe.
  task automatic cycle();
    if (reset && m_valid && m_ready) rx.push_back(m_data);
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    if (dropped) drop_cnt++;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NP; i++) v[i*AW +: AW] = $urandom;
    return v;
  endfunction

  // Reference frame: sync, class, scores little-endian, optional XOR of all but sync.
  task automatic build_model(input logic [VW-1:0] v, input logic [3:0] c);
    logic [7:0]    x;
    logic [AW-1:0] word;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'h0, c});
    x = {4'h0, c};
    for (int w = 0; w < NP; w++) begin
      word = v[w*AW +: AW];
      for (int i = 0; i < AW / 8; i++) begin
        exp_q.push_back(word[7:0]);
        x = x ^ word[7:0];
        word = word >> 8;
      end
    end
`ifdef MNIST_STREAM_CKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic start_frame(input string tag, input logic [VW-1:0] v, input logic [3:0] c);
    rx.delete();
    build_model(v, c);
    result_vector   = v;
    predicted_class = c;
    done_in         = 1'b1;
    m_ready         = 1'b1;
    cycle();
    done_in         = 1'b0;
    result_vector   = rand_vec();
    predicted_class = 4'($urandom);
    check({tag, " first valid"}, m_valid, 1);
    check({tag, " first byte"}, m_data, 8'hA5);
    check({tag, " busy"}, busy, 1);
  endtask

  task automatic drain(input string tag, input int stall_pct, input int junk_pct,
                       input int budget, output int cycles);
    int         start_fd;
    logic       stalled, junk;
    logic [7:0] held;
    start_fd = fd_cnt;
    cycles = 0;
    while (fd_cnt == start_fd && cycles < budget) begin
      m_ready = ($urandom_range(0, 99) >= stall_pct);
      junk    = ($urandom_range(0, 99) < junk_pct);
      done_in = junk;
      result_vector   = rand_vec();
      predicted_class = 4'($urandom);
      stalled = m_valid && !m_ready;
      held    = m_data;
      cycle();
      cycles++;
      done_in = 1'b0;
      if (stalled) begin
        check({tag, " hold valid"}, m_valid, 1);
        check({tag, " hold data"}, m_data, held);
      end
      if (junk) check({tag, " drop pulse"}, dropped, 1);
      if (fd_cnt == start_fd) check({tag, " busy mid"}, busy, 1);
    end
    if (fd_cnt == start_fd) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no frame_done within %0d cycles", tag, budget);
    end else begin
      check({tag, " busy end"}, busy, 0);
      check({tag, " valid end"}, m_valid, 0);
    end
  endtask

  task automatic compare_frame(input string tag);
    check({tag, " length"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      check($sformatf("%s byte%0d", tag, i), rx[i], exp_q[i]);
  endtask

  initial begin
    int cyc, d0, f0;
    logic [VW-1:0] v;

    for (int k = 0; k < NP; k++) v[k*AW +: AW] = AW'(k + 1);
    tbl[0] = '{v, 4'd9, 8'h02, 8'h00};
    tbl[1] = '{'0, 4'd0, 8'h00, 8'h00};
    tbl[2] = '{{NP{32'hFFFF_FFFF}}, 4'd5, 8'h05, 8'hFF};
    tbl[3] = '{{NP{32'h0102_0304}}, 4'hF, 8'h0F, 8'h01};

    reset = 1'b0; done_in = 1'b0; m_ready = 1'b0;
    result_vector = '0; predicted_class = '0;
    cycle(); cycle();
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    check("reset dropped", dropped, 0);
    reset = 1'b1;
    cycle();

    // Table frames with m_ready held high: gap-free, exact length, known last byte.
    for (int t = 0; t < 4; t++) begin
      start_frame($sformatf("tbl%0d", t), tbl[t].vec, tbl[t].cls);
      drain($sformatf("tbl%0d", t), 0, 0, 200, cyc);
      check($sformatf("tbl%0d cycles", t), cyc, FRAME_LEN);
      compare_frame($sformatf("tbl%0d", t));
`ifdef MNIST_STREAM_CKSUM_EN
      if (rx.size() > 0) check($sformatf("tbl%0d last", t), rx[rx.size()-1], tbl[t].last_ck);
`else
      if (rx.size() > 0) check($sformatf("tbl%0d last", t), rx[rx.size()-1], tbl[t].last_pl);
`endif
      cycle();
      check($sformatf("tbl%0d done one-shot", t), frame_done, 0);
    end

    // Stall five cycles while byte index 2 is presented.
    start_frame("stall", tbl[0].vec, tbl[0].cls);
    cycle(); cycle();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("stall valid%0d", i), m_valid, 1);
      check($sformatf("stall data%0d", i), m_data, 8'h01);
    end
    drain("stall", 0, 0, 200, cyc);
    compare_frame("stall");

    // done_in mid-frame is dropped and does not disturb the frame.
    start_frame("drop", tbl[0].vec, tbl[0].cls);
    for (int i = 0; i < 10; i++) cycle();
    d0 = drop_cnt;
    done_in = 1'b1; predicted_class = 4'd3; result_vector = tbl[2].vec;
    cycle();
    done_in = 1'b0;
    check("drop pulse", dropped, 1);
    cycle();
    check("drop one-shot", dropped, 0);
    drain("drop", 0, 0, 200, cyc);
    check("drop count", drop_cnt - d0, 1);
    compare_frame("drop");

    // Reset mid-frame abandons it; idle m_ready has no effect; next frame is fresh.
    start_frame("rst", tbl[0].vec, tbl[0].cls);
    for (int i = 0; i < 19; i++) cycle();
    f0 = fd_cnt;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("rst m_valid", m_valid, 0);
    check("rst busy", busy, 0);
    m_ready = 1'b1;
    cycle(); cycle(); cycle();
    check("rst no frame_done", fd_cnt - f0, 0);
    check("rst idle valid", m_valid, 0);
    start_frame("post-rst", tbl[2].vec, tbl[2].cls);
    drain("post-rst", 0, 0, 200, cyc);
    compare_frame("post-rst");

    // done_in during the frame_done cycle is accepted.
    start_frame("b2b-a", tbl[3].vec, tbl[3].cls);
    drain("b2b-a", 0, 0, 200, cyc);
    compare_frame("b2b-a");
    check("b2b frame_done now", frame_done, 1);
    start_frame("b2b-b", tbl[1].vec, 4'd7);
    check("b2b no drop", dropped, 0);
    drain("b2b-b", 0, 0, 200, cyc);
    compare_frame("b2b-b");

    // Random frames with random backpressure and spurious done_in pulses.
    for (int r = 0; r < 8; r++) begin
      start_frame($sformatf("rnd%0d", r), rand_vec(), 4'($urandom_range(0, 9)));
      drain($sformatf("rnd%0d", r), 35, 6, 3000, cyc);
      compare_frame($sformatf("rnd%0d", r));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
